lsu: RTL
========

# lsu

Load/store unit sitting directly upstream of the data `ram`, translating RV32I load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) into the word-only memory interface. Loads are extracted and sign- or zero-extended. Sub-word stores are handled by a read-modify-write sequence, because the memory only writes whole words. A single-outstanding valid/ready request port faces the execute stage, and a one-cycle response pulse returns the result.

## Interface
- `WORDSIZE`, 4: memory word width in bytes; fixed at 4 for RV32.
- `MEMSIZE`, 32*1024: memory size in bytes; sets the `mem_address` width.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I funct3 (size and signedness).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_error` output 1: request rejected, valid only with `resp_valid`.
- `mem_write_en` output 1: to ram `write_en`.
- `mem_address` output $clog2(MEMSIZE): to ram `address`; always word-aligned (low 2 bits 0).
- `mem_wdata` output 32: to ram `data_i`.
- `mem_rdata` input 32: from ram `data_o`, combinational read of `mem_address`.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: `req_ready`=1. On accept, latch write, funct3, address (truncated to $clog2(MEMSIZE) bits) and wdata, then go to ACCESS. Upper address bits are silently dropped.
- ACCESS: drive `mem_address` = {latched addr[hi:2], 2'b00}.
  - Load: capture the extended data into `resp_rdata`, then go to RESP.
  - SW: assert `mem_write_en` with `mem_wdata`=wdata, then go to RESP.
  - SB/SH: register `mem_rdata` as the merge word, then go to WRITE.
- WRITE: assert `mem_write_en` with the merge word, replacing byte lane addr[1:0] (SB) or halfword lane addr[1] (SH) with wdata[7:0] or wdata[15:0]. Other lanes are preserved. Then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Byte order is little-endian.
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Illegal funct3 (load 011/110/111; store ≥011): no memory access and no write. ACCESS goes to RESP with `resp_error`=1 and `resp_rdata`=0. This applies in every configuration.
- `mem_write_en` is combinational from state and gated by `!reset`, so no memory write occurs in any cycle with `reset` high.

## Timing
- Reset values: state IDLE; `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `mem_write_en`=0, `mem_address`=0, `mem_wdata`=0.
- Accept at edge N. `resp_valid` is high in cycle N+2 for loads, SW and errors, and in cycle N+3 for SB/SH.
- `req_ready` is low from cycle N+1 until the cycle after RESP. The earliest back-to-back accept is the edge ending the first IDLE cycle after RESP.
- `resp_rdata` and `resp_error` hold their values until the next RESP or reset.
- Reset mid-operation: the transaction is abandoned with no write and no response, and the unit enters IDLE at the next edge.
- A store followed by a load to the same word returns the new data, because the write is committed before RESP.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, are treated as errors (no access, `resp_error`=1, latency 2).
- Undefined:
  - Low address bits are ignored per size: halfword ignores addr[0], word ignores addr[1:0].
  - `resp_error` is raised only for illegal funct3.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x100 -> `mem_write_en` high exactly in N+1 at address 0x100; `resp_valid` in N+2; `resp_error`=0.
- LB 0x103 / LBU 0x103 after the above -> `resp_rdata`=0xFFFFFFDE / 0x000000DE; LH 0x102 -> 0xFFFFDEAD.
- SB 0x55 to 0x101 over 0xDEADBEEF -> a single write in N+2 of 0xDEAD55EF; `resp_valid` in N+3; then LW 0x100 returns 0xDEAD55EF.
- LW 0x102 -> with macro: `resp_error`=1, `resp_rdata`=0, no write. Without macro: returns the word at 0x100.
- Load with funct3=011 -> `resp_error`=1 in both builds; `mem_write_en` never asserted.
- SH in flight, `reset` raised in the WRITE cycle -> the memory word is unchanged, no `resp_valid`, and `req_ready`=1 the next cycle.

Source files
------------

// File: rtl/lsu_if.sv
// Request/response bus between the execute stage and the load/store unit.
// master: execute stage issuing requests; slave: the lsu.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit in front of a word-only RAM with combinational read.
// Sub-word stores use read-modify-write (ACCESS reads, WRITE commits).
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned halfword/word accesses
// become errors instead of silently ignoring the low address bits.
module lsu #(
    parameter int unsigned WORDSIZE = 4,
    parameter int unsigned MEMSIZE  = 32 * 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    lsu_if.slave                       bus,
    output logic                       mem_write_en,
    output logic [$clog2(MEMSIZE)-1:0] mem_address,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata
);
    localparam int unsigned AW   = $clog2(MEMSIZE);
    localparam int unsigned LANE = $clog2(WORDSIZE);

    typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

    state_e      r_state;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [AW-1:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_error;

    logic        w_error;
    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unused_addr;

    // Address bits above the memory size are dropped on purpose.
    assign w_unused_addr = ^bus.req_addr[31:AW];

    // Decode illegal funct3 (and, optionally, misalignment) for the latched request.
    always_comb begin
        w_error = 1'b0;
        if (r_write) begin
            w_error = r_funct3[2] | (r_funct3[1:0] == 2'b11);
        end else begin
            w_error = (r_funct3 == 3'b011) | (r_funct3[2:1] == 2'b11);
        end
`ifdef LSU_MISALIGN_CHECK_EN
        if (r_funct3[1:0] == 2'b01 && r_addr[0]) begin
            w_error = 1'b1;
        end
        if (r_funct3[1:0] == 2'b10 && r_addr[1:0] != 2'b00) begin
            w_error = 1'b1;
        end
`endif
    end

    // Select the addressed lane and extend it to 32 bits (little-endian).
    always_comb begin
        unique case (r_addr[1:0])
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            3'b010:  w_load = mem_rdata;
            default: w_load = 32'h0;
        endcase
    end

    // Overlay the store byte/halfword onto the word captured in ACCESS.
    always_comb begin
        w_merged = r_merge;
        if (r_funct3[1:0] == 2'b00) begin
            unique case (r_addr[1:0])
                2'b00:   w_merged[7:0]   = r_wdata[7:0];
                2'b01:   w_merged[15:8]  = r_wdata[7:0];
                2'b10:   w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0] = r_wdata[15:0];
        end
    end

    // Transaction FSM; response data/error change only on entry to RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= StIdle;
            r_write  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_merge  <= 32'h0;
            r_rdata  <= 32'h0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_write  <= bus.req_write;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr[AW-1:0];
                        r_wdata  <= bus.req_wdata;
                        r_state  <= StAccess;
                    end
                end
                StAccess: begin
                    if (w_error) begin
                        r_error <= 1'b1;
                        r_rdata <= 32'h0;
                        r_state <= StResp;
                    end else if (!r_write) begin
                        r_error <= 1'b0;
                        r_rdata <= w_load;
                        r_state <= StResp;
                    end else if (r_funct3[1:0] == 2'b10) begin
                        r_error <= 1'b0;
                        r_rdata <= 32'h0;
                        r_state <= StResp;
                    end else begin
                        r_merge <= mem_rdata;
                        r_state <= StWrite;
                    end
                end
                StWrite: begin
                    r_error <= 1'b0;
                    r_rdata <= 32'h0;
                    r_state <= StResp;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs decoded from state; writes are suppressed while reset is high.
    always_comb begin
        bus.req_ready  = (r_state == StIdle);
        bus.resp_valid = (r_state == StResp);
        bus.resp_rdata = r_rdata;
        bus.resp_error = r_error;
        mem_address    = {r_addr[AW-1:LANE], {LANE{1'b0}}};
        mem_wdata      = (r_state == StWrite) ? w_merged : r_wdata;
        mem_write_en   = !reset && ((r_state == StWrite) ||
                         (r_state == StAccess && r_write && !w_error &&
                          r_funct3[1:0] == 2'b10));
    end
endmodule
